// File: rtl/mask_centroid_pkg.sv
// Shared widths and FSM encoding for the mask centroid block.
package mask_centroid_pkg;
    localparam int COORD_W = 10;
    localparam int SUM_W   = 32;
    localparam int CNT_W   = 20;

    typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, REPORT} state_t;
endpackage

// File: rtl/mask_centroid_divider.sv
// Restoring serial divider: one quotient bit per ce-cycle, DW cycles per division.
// The start cycle already performs the first step, so done marks the DW-th step.
module serial_divider
    import mask_centroid_pkg::*;
#(
    parameter int DW = SUM_W,
    parameter int VW = CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient
);
    localparam int SW = $clog2(DW);

    logic [VW-1:0] rem;
    logic [SW-1:0] steps;
    logic [DW-1:0] q_src;
    logic [VW-1:0] r_src;
    logic [VW:0]   trial;
    logic          fits;

    always_comb begin
        q_src = start ? dividend : quotient;
        r_src = start ? '0 : rem;
        trial = {r_src, q_src[DW-1]};
        fits  = trial >= {1'b0, divisor};
        done  = busy && (steps == SW'(DW - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem      <= '0;
            steps    <= '0;
            busy     <= 1'b0;
            quotient <= '0;
        end else if (ce && (start || busy)) begin
            quotient <= {q_src[DW-2:0], fits};
            // trial < 2*divisor, so the restored remainder always fits in VW bits
            rem      <= fits ? VW'(trial - {1'b0, divisor}) : trial[VW-1:0];
            if (start) begin
                busy  <= 1'b1;
                steps <= SW'(1);
            end else if (done) begin
                busy  <= 1'b0;
                steps <= '0;
            end else begin
                steps <= steps + SW'(1);
            end
        end
    end
endmodule

// File: rtl/mask_centroid.sv
// Accumulates mask=1 pixel coordinates per frame and reports the centroid
// after a serial x then y division, triggered by the vsync rising edge.
module mask_centroid
    import mask_centroid_pkg::*;
#(
    parameter int H_SIZE    = 83,
    parameter int V_SIZE    = 64,
    parameter int MIN_COUNT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               mask,
    input  logic               in_de,
    input  logic               in_vsync,
    input  logic               in_hsync,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy,
    output logic [CNT_W-1:0]   pix_count,
    output logic               found,
    output logic               c_valid,
    output logic               overrun
);
    logic               vsync_d, de_d;
    logic [COORD_W-1:0] x, y, y_pix, quo_x;
    logic [SUM_W-1:0]   sum_x, sum_y, snap_x, snap_y;
    logic [CNT_W-1:0]   count, snap_cnt;
    logic               frame_end, pix, zero_cnt;
    state_t             state, next;
    logic               start, sel_y, busy, done;
    logic [SUM_W-1:0]   quot;
    logic               unused_bits;

    assign unused_bits = in_hsync ^ (^quot[SUM_W-1:COORD_W]);

    assign frame_end = in_vsync & ~vsync_d;
    assign pix       = in_de & mask;
    assign zero_cnt  = (snap_cnt == '0);
    // a pixel on the frame-end cycle already belongs to the new frame (row 0)
    assign y_pix     = frame_end ? '0 : y;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d  <= 1'b0;
            de_d     <= 1'b0;
            x        <= '0;
            y        <= '0;
            sum_x    <= '0;
            sum_y    <= '0;
            count    <= '0;
            snap_x   <= '0;
            snap_y   <= '0;
            snap_cnt <= '0;
        end else if (ce) begin
            vsync_d <= in_vsync;
            de_d    <= in_de;
            if (!in_de)
                x <= '0;
            else if (x != COORD_W'(H_SIZE - 1))
                x <= x + COORD_W'(1);
            if (frame_end)
                y <= '0;
            else if (de_d && !in_de && y != COORD_W'(V_SIZE - 1))
                y <= y + COORD_W'(1);
            if (frame_end) begin
                sum_x <= pix ? SUM_W'(x) : '0;
                sum_y <= pix ? SUM_W'(y_pix) : '0;
                count <= CNT_W'(pix);
            end else if (pix) begin
                sum_x <= sum_x + SUM_W'(x);
                sum_y <= sum_y + SUM_W'(y_pix);
                count <= count + CNT_W'(1);
            end
            if (frame_end && state == IDLE) begin
                snap_x   <= sum_x;
                snap_y   <= sum_y;
                snap_cnt <= count;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)     state <= IDLE;
        else if (ce) state <= next;
    end

    always_comb begin
        next  = state;
        start = 1'b0;
        sel_y = 1'b0;
        case (state)
            IDLE:   if (frame_end) next = DIV_X;
            DIV_X: begin
                if (zero_cnt) begin
                    next = REPORT;
                end else begin
                    start = !busy;
                    if (done) next = DIV_Y;
                end
            end
            DIV_Y: begin
                sel_y = 1'b1;
                start = !busy;
                if (done) next = REPORT;
            end
            REPORT: next = IDLE;
            default: next = IDLE;
        endcase
    end

    serial_divider #(.DW(SUM_W), .VW(CNT_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .start    (start),
        .dividend (sel_y ? snap_y : snap_x),
        .divisor  (snap_cnt),
        .busy     (busy),
        .done     (done),
        .quotient (quot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_x     <= '0;
            cx        <= '0;
            cy        <= '0;
            pix_count <= '0;
            found     <= 1'b0;
            c_valid   <= 1'b0;
            overrun   <= 1'b0;
        end else if (ce) begin
            c_valid <= (state == REPORT);
            overrun <= frame_end && (state != IDLE);
            // the x quotient is still intact on the cycle the y division starts
            if (sel_y && start)
                quo_x <= quot[COORD_W-1:0];
            if (state == REPORT) begin
                cx        <= zero_cnt ? '0 : quo_x;
                cy        <= zero_cnt ? '0 : quot[COORD_W-1:0];
                pix_count <= snap_cnt;
                found     <= snap_cnt >= CNT_W'(MIN_COUNT);
            end
        end
    end
endmodule
